serial_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 16 +
 rtl/full_adder.sv | 15 +
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: default width and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_pkg;

    // Operand width used when the instantiating logic does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states; encodings are fixed so debug probes read consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: sum and carry-out of three input bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Latency: done pulses after WIDTH edges following the accepted start edge; one result per WIDTH+2 cycles.
// Backpressure: start is only honoured in IDLE; requests during SHIFT/DONE are ignored, not queued.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must be able to hold WIDTH-1 even when WIDTH is 1.
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_cout;

    // Single adder cell; always looks at the current LSBs and the running carry.
    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // sum/cout keep the previous result until a new one completes.
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d             = a_sh_q >> 1;
                b_sh_d             = b_sh_q >> 1;
                // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at sum[0].
                sum_d              = sum_q >> 1;
                sum_d[WIDTH-1]     = fa_sum;
                carry_d            = fa_cout;
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = fa_cout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and swept checks of serial_adder at WIDTH=8.
// Latency: checks done arrives WIDTH edges after the start edge and lasts one cycle.
// Backpressure: checks start is ignored outside IDLE.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total;
    int bad;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation: single-cycle start, then watch busy/done for WIDTH+3 samples.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [WIDTH-1:0] sum_at_done;
        logic             cout_at_done;
        busy_cnt     = 0;
        done_cnt     = 0;
        done_at      = -1;
        sum_at_done  = '0;
        cout_at_done = 1'b0;
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= WIDTH + 2; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (done_at < 0) begin
                    done_at      = k;
                    sum_at_done  = sum;
                    cout_at_done = cout;
                end
                done_cnt++;
            end
        end
        chk({tag, ".done_at"}, 32'(done_at), 32'(WIDTH));
        chk({tag, ".done_width"}, 32'(done_cnt), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        chk({tag, ".sum"}, 32'(sum_at_done), 32'(exp_sum));
        chk({tag, ".cout"}, 32'(cout_at_done), 32'(exp_cout));
        chk({tag, ".sum_hold"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        logic [WIDTH:0] ref_v;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic             cv;
        int               seen_done;

        total = 0;
        bad   = 0;

        // Reset held with start asserted: everything stays cleared.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hA5;
        b     = 8'h5A;
        cin   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.sum", 32'(sum), 32'h00);
        chk("rst.cout", 32'(cout), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.done", 32'(done), 32'd0);

        // Carry ripples through every bit.
        run_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        // Carry-in with maximum operands.
        run_op("max", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("mix", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);

        // start held high; operands change mid-SHIFT and must not matter.
        @(negedge clk);
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("held.busy_e0", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        a = 8'hAA;
        b = 8'h55;
        repeat (WIDTH - 3) @(posedge clk);
        #1;
        chk("held.done", 32'(done), 32'd1);
        chk("held.sum", 32'(sum), 32'h46);
        chk("held.cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        chk("held.busy_done_state", 32'(busy), 32'd0);
        chk("held.done_low", 32'(done), 32'd0);
        chk("held.sum_hold1", 32'(sum), 32'h46);
        @(posedge clk);
        #1;
        chk("held.reaccept", 32'(busy), 32'd1);
        chk("held.sum_hold2", 32'(sum), 32'h46);
        start = 1'b0;
        repeat (WIDTH) @(posedge clk);
        #1;
        chk("held2.done", 32'(done), 32'd1);
        chk("held2.sum", 32'(sum), 32'hFF);
        chk("held2.cout", 32'(cout), 32'd0);
        repeat (2) @(posedge clk);

        // Reset in the middle of SHIFT: immediate clear, no done pulse.
        @(negedge clk);
        a     = 8'hF0;
        b     = 8'h0F;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.sum", 32'(sum), 32'h00);
        chk("abort.cout", 32'(cout), 32'd0);
        seen_done = 0;
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (k == 1) rst_n = 1'b1;
        end
        chk("abort.no_done", 32'(seen_done), 32'd0);
        run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Swept operands against the arithmetic reference.
        for (int i = 0; i < 256; i++) begin
            av    = 8'(i);
            bv    = 8'((i * 73 + 11) & 255);
            cv    = 1'(i & 1);
            ref_v = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
            run_op("sweep", av, bv, cv, ref_v[WIDTH-1:0], ref_v[WIDTH]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
